amp_offset_cal_ctrl: RTL
========================

Name: amp_offset_cal_ctrl

Overview:
Digital sequencer for the self-biased differential amplifier when it is used as a comparator. It powers up the amplifier and shorts its inputs. It then runs a successive-approximation search over an offset-trim code, using the amplifier output as the decision bit. After calibration it releases the input short and holds the trim code. It sits in the digital PnR region beside the analog macro and drives the macro's enable, short switch and trim DAC.

Parameters:
TRIM_BITS, 6, width of the offset-trim code (legal range 2..8).
PWRUP_CYCLES, 16, cycles to wait after amp_en rises before the first SAR step (legal range >=1).
SETTLE_CYCLES, 8, cycles allowed for each trim step to settle before sampling (legal range >=3, which covers the 2-flop synchronizer).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle request to begin calibration; ignored while busy.
abort  in  1  cancels a calibration in progress.
enable  in  1  level; keeps the amplifier powered outside calibration.
amp_out  in  1  asynchronous comparator output from the analog macro.
amp_en  out  1  amplifier bias enable.
cal_short  out  1  closes the switch that shorts inputs a and b.
trim  out  TRIM_BITS  offset-trim code to the DAC.
busy  out  1  calibration in progress.
done  out  1  one-cycle pulse when calibration completes.
sat  out  1  last calibration ended at code all-0 or all-1.

Behaviour:
Reset and synchronizer
- Reset is synchronous, active-high. On reset: state=IDLE, amp_en=0, cal_short=0, trim=0, busy=0, done=0, sat=0, synchronizer flops=0.
- amp_out passes through a 2-flop synchronizer, giving amp_s. All decisions use amp_s only.

State machine: IDLE, PWRUP, SETTLE, SAMPLE, DONE.
- IDLE
  - busy=0, cal_short=0, amp_en=enable, trim holds its value.
  - start=1 → PWRUP. On that same edge:
    - save_trim ← trim
    - trim ← MSB-only code (1000…)
    - bit_idx ← TRIM_BITS-1
    - cnt ← PWRUP_CYCLES-1
- PWRUP
  - amp_en=1, cal_short=1, busy=1.
  - cnt decrements each cycle. At cnt==0 → SETTLE, with cnt ← SETTLE_CYCLES-1.
  - State duration is exactly PWRUP_CYCLES cycles.
- SETTLE
  - Outputs as PWRUP.
  - cnt decrements. At cnt==0 → SAMPLE.
  - State duration is exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle)
  - If amp_s=1 (trim too high), clear trim[bit_idx].
  - If bit_idx>0: set trim[bit_idx-1], decrement bit_idx, reload cnt ← SETTLE_CYCLES-1, → SETTLE.
  - If bit_idx==0 → DONE.
- DONE (1 cycle)
  - busy=0, done=1, cal_short=0, amp_en=1.
  - sat ← (trim==0) or (trim==all-ones).
  - → IDLE.

Timing and edge cases
- Latency from the start edge: busy is high for PWRUP_CYCLES + TRIM_BITS*(SETTLE_CYCLES+1) cycles. done pulses on the next cycle.
- start while busy: ignored. start in the DONE cycle: ignored.
- abort in any busy state (PWRUP, SETTLE or SAMPLE) → IDLE on the next edge:
  - trim ← save_trim
  - cal_short=0
  - done stays 0
  - sat unchanged
  - abort takes priority over a SAMPLE update in the same cycle.
- abort in IDLE or DONE: no effect.
- start and abort asserted together in IDLE: start wins.
- enable has no effect while busy: amp_en is forced to 1.
- sat holds its value until the next DONE or until reset.
- Reset mid-calibration: all outputs go to reset values, including trim=0; save_trim is discarded.

Test Plan:
1. Params 4/8/4; model amp_out=(trim>5); pulse start → busy high 28 cycles, trim steps 8→4→6→5, final trim=5, done pulses 1 cycle, sat=0, cal_short falls with done.
2. amp_out tied 1 → trim=0000, sat=1; amp_out tied 0 → trim=1111, sat=1; a rerun with a mid-range model clears sat to 0.
3. Abort: preload trim=5 via a completed cal, restart, assert abort in 3rd SETTLE → next cycle IDLE, trim=5, cal_short=0, no done pulse.
4. start pulsed during busy and in the DONE cycle → ignored; cycle counts unchanged, no second calibration.
5. enable=0 in IDLE → amp_en=0; enable=1 → amp_en=1 next edge; enable=0 during calibration → amp_en stays 1 until return to IDLE.
6. Assert rst in SAMPLE → next cycle all outputs 0, state IDLE; a new start runs a full 28-cycle calibration correctly.

Source files
------------

// File: rtl/amp_offset_cal_if.sv
// Control/status bundle between the offset-calibration sequencer and whatever drives it.
// The bench or system side uses the master modport and the sequencer uses the slave modport.
interface amp_offset_cal_if #(
  parameter int TRIM_BITS = 6
) ();
  logic                 start;
  logic                 abort;
  logic                 enable;
  logic                 amp_out;
  logic                 amp_en;
  logic                 cal_short;
  logic [TRIM_BITS-1:0] trim;
  logic                 busy;
  logic                 done;
  logic                 sat;

  modport master (
    output start, abort, enable, amp_out,
    input  amp_en, cal_short, trim, busy, done, sat
  );

  modport slave (
    input  start, abort, enable, amp_out,
    output amp_en, cal_short, trim, busy, done, sat
  );
endinterface

// File: rtl/amp_offset_cal_ctrl.sv
// Offset-trim sequencer for the differential amplifier used as a comparator.
// It powers up the amplifier, shorts its inputs, runs a SAR search on the trim code, then holds the result.
module amp_offset_cal_ctrl #(
  parameter int TRIM_BITS     = 6,
  parameter int PWRUP_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input logic             clk,
  input logic             rst,
  amp_offset_cal_if.slave bus
);

  localparam int IDX_W   = $clog2(TRIM_BITS);
  localparam int CNT_MAX = (PWRUP_CYCLES > SETTLE_CYCLES) ? PWRUP_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     PWRUP_LOAD  = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_TOP     = IDX_W'(TRIM_BITS - 1);
  localparam logic [TRIM_BITS-1:0] CODE_MSB    = {1'b1, {(TRIM_BITS-1){1'b0}}};
  localparam logic [TRIM_BITS-1:0] CODE_ZERO   = {TRIM_BITS{1'b0}};
  localparam logic [TRIM_BITS-1:0] CODE_ONES   = {TRIM_BITS{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic code_at_rail(input logic [TRIM_BITS-1:0] code);
    return (code == CODE_ZERO) || (code == CODE_ONES);
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [TRIM_BITS-1:0] trim_q, trim_d;
  logic [TRIM_BITS-1:0] save_trim_q, save_trim_d;
  logic                 sat_q, sat_d;
  logic                 amp_en_q, amp_en_d;
  logic                 cal_short_q, cal_short_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sync1_q, amp_s_q;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      amp_s_q <= 1'b0;
    end else begin
      sync1_q <= bus.amp_out;
      amp_s_q <= sync1_q;
    end
  end

  // Next-state logic; sat is updated on entry to DONE so it is valid alongside the done pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    trim_d      = trim_q;
    save_trim_d = save_trim_q;
    sat_d       = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_PWRUP;
          save_trim_d = trim_q;
          trim_d      = CODE_MSB;
          bit_idx_d   = IDX_TOP;
          cnt_d       = PWRUP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PWRUP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          trim_d  = save_trim_q;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          trim_d  = save_trim_q;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          trim_d  = save_trim_q;
        end else begin
          // A high comparator output means the code overshoots, so the trial bit is dropped.
          if (amp_s_q) begin
            trim_d[bit_idx_q] = 1'b0;
          end else begin
            trim_d[bit_idx_q] = trim_q[bit_idx_q];
          end
          if (bit_idx_q != {IDX_W{1'b0}}) begin
            trim_d[bit_idx_q - 1'b1] = 1'b1;
            bit_idx_d                = bit_idx_q - 1'b1;
            cnt_d                    = SETTLE_LOAD;
            state_d                  = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
            sat_d   = code_at_rail(trim_d);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so that every output leaves a flop.
  always_comb begin
    amp_en_d    = 1'b1;
    cal_short_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      ST_IDLE: begin
        amp_en_d = bus.enable;
      end
      ST_PWRUP, ST_SETTLE, ST_SAMPLE: begin
        cal_short_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        amp_en_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      bit_idx_q   <= {IDX_W{1'b0}};
      trim_q      <= CODE_ZERO;
      save_trim_q <= CODE_ZERO;
      sat_q       <= 1'b0;
      amp_en_q    <= 1'b0;
      cal_short_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      trim_q      <= trim_d;
      save_trim_q <= save_trim_d;
      sat_q       <= sat_d;
      amp_en_q    <= amp_en_d;
      cal_short_q <= cal_short_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.amp_en    = amp_en_q;
  assign bus.cal_short = cal_short_q;
  assign bus.trim      = trim_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sat       = sat_q;

endmodule
